// File: rtl/ls_logic_pkg.sv
// Shared constants and helpers for the 74LS-series compatible logic blocks.
package ls_logic_pkg;

    // Inactive a_n value, also shared by the EI-disabled and no-key cases
    localparam logic [2:0] ENC_IDLE_A = 3'b111;

    // Strobe FSM state encodings
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    // {valid, idx}: valid when any active-low input is low, idx of the highest one
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // 8-input priority search over active-low inputs, bit 7 wins
    function automatic prio_t prio148(input logic [7:0] v_n);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!v_n[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser plus counter debouncer for one active-low key line.
module debounce_bit #(
    parameter int unsigned DEB_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key line into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from deb for DEB_CYCLES edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb <= 1'b1;
            cnt <= '0;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_encoder_148.sv
// Debounced 8-to-3 priority key encoder with 74LS148 outputs and change strobe.
module key_encoder_148 #(
    parameter int unsigned DEB_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_n,
    input  logic       ei_n,
    output logic [2:0] a_n,
    output logic       gs_n,
    output logic       eo_n,
    output logic [2:0] key_code,
    output logic       key_stb
);

    import ls_logic_pkg::*;

    logic [7:0] deb_n;
    logic       ei_sync1;
    logic       ei_sync2;
    prio_t      enc;
    logic [2:0] a_nxt;
    logic       gs_nxt;
    logic       eo_nxt;
    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [2:0] code_nxt;
    logic       stb_nxt;

    // One debouncer per key line
    for (genvar g = 0; g < 8; g++) begin : g_deb
        debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (in_n[g]),
            .deb  (deb_n[g])
        );
    end

    // Synchronise the enable input; EI has no debounce
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ei_sync1 <= 1'b1;
            ei_sync2 <= 1'b1;
        end else begin
            ei_sync1 <= ei_n;
            ei_sync2 <= ei_sync1;
        end
    end

    // 74LS148 encode of the debounced keys
    always_comb begin
        enc    = prio148(deb_n);
        a_nxt  = ENC_IDLE_A;
        gs_nxt = 1'b1;
        eo_nxt = 1'b1;
        if (!ei_sync2) begin
            if (enc.valid) begin
                a_nxt  = ~enc.idx;
                gs_nxt = 1'b0;
            end else begin
                eo_nxt = 1'b0;
            end
        end
    end

    // Strobe FSM next state: fire on a fresh selection or a change of key
    always_comb begin
        state_nxt = state;
        code_nxt  = key_code;
        stb_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!gs_nxt) begin
                    state_nxt = HELD;
                    code_nxt  = enc.idx;
                    stb_nxt   = 1'b1;
                end
            end
            HELD: begin
                if (gs_nxt) begin
                    state_nxt = IDLE;
                end else if (enc.idx != key_code) begin
                    code_nxt = enc.idx;
                    stb_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register encoder outputs, FSM state and strobe together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_n      <= ENC_IDLE_A;
            gs_n     <= 1'b1;
            eo_n     <= 1'b1;
            key_code <= 3'd0;
            key_stb  <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_n      <= a_nxt;
            gs_n     <= gs_nxt;
            eo_n     <= eo_nxt;
            key_code <= code_nxt;
            key_stb  <= stb_nxt;
        end
    end

endmodule
